// File: rtl/td_decoder_if.sv
// Start/result bundle of the time-domain decoder.
// The master drives the request side; the slave returns the measurement.
interface td_decoder_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             pol;
    logic             td_in;
    logic             out_ready;
    logic [CNT_W-1:0] value;
    logic             timeout;
    logic             valid;
    logic             busy;

    modport master (
        output start, pol, td_in, out_ready,
        input  value, timeout, valid, busy
    );

    modport slave (
        input  start, pol, td_in, out_ready,
        output value, timeout, valid, busy
    );
endinterface

// File: rtl/td_decoder.sv
// Time-domain decoder: counts clk cycles from start until the selected edge
// appears on the synchronized td_in, then holds the result until accepted.
module td_decoder #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    td_decoder_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       value_r;
    logic                   timeout_r;
    logic                   valid_r;
    logic                   busy_r;
    logic                   pol_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_prev_r;
    logic                   sync_out_s;
    logic                   det_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    // Free-running td_in synchronizer plus one extra flop for edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r      <= {SYNC_STAGES{1'b0}};
            sync_prev_r <= 1'b0;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], bus.td_in};
            sync_prev_r <= sync_out_s;
        end
    end

    // Edge detector for the polarity latched at start.
    always_comb begin
        det_s = 1'b0;
        case (pol_r)
            1'b0:    det_s = sync_out_s & ~sync_prev_r;
            1'b1:    det_s = ~sync_out_s & sync_prev_r;
            default: det_s = 1'b0;
        endcase
    end

    // Measurement FSM with registered result and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            value_r   <= CNT_ZERO;
            timeout_r <= 1'b0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            pol_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r   <= COUNT;
                        cnt_r     <= CNT_ZERO;
                        pol_r     <= bus.pol;
                        timeout_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end
                COUNT: begin
                    // A detected edge beats saturation on the same cycle.
                    if (det_s) begin
                        value_r   <= cnt_r;
                        timeout_r <= 1'b0;
                        valid_r   <= 1'b1;
                        state_r   <= HOLD;
                    end else if (cnt_r == CNT_MAX) begin
                        value_r   <= CNT_MAX;
                        timeout_r <= 1'b1;
                        valid_r   <= 1'b1;
                        state_r   <= HOLD;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.value   = value_r;
    assign bus.timeout = timeout_r;
    assign bus.valid   = valid_r;
    assign bus.busy    = busy_r;
endmodule

// File: tb/tb_td_decoder.sv
// Self-checking bench for td_decoder: directed measurements against an
// edge-history reference model plus hand-computed literal results.
module tb_td_decoder;
    localparam int CNT_W = 8;
    localparam int S     = 2;
    localparam int MAXV  = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    td_decoder_if #(.CNT_W(CNT_W)) bus_if ();

    td_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: td_in sampled at every clk edge, result derived from edge indices.
    bit td_hist [0:8191];
    int ecnt      = -1;
    int rst_floor = 0;
    int m_ph      = 0;
    int e0        = 0;
    bit m_pol     = 1'b0;
    int m_value   = 0;
    bit m_timeout = 1'b0;
    bit m_valid   = 1'b0;
    bit m_busy    = 1'b0;

    function automatic bit samp(int i);
        if (i < 0 || i <= rst_floor) return 1'b0;
        return td_hist[i];
    endfunction

    always @(posedge clk) begin : model
        int k;
        int el;
        bit a;
        bit b;
        bit hit;
        ecnt = ecnt + 1;
        k = ecnt;
        td_hist[k] = bus_if.td_in;
        if (!rst_n) begin
            rst_floor = k;
            m_ph = 0; m_value = 0; m_timeout = 1'b0; m_valid = 1'b0; m_busy = 1'b0;
        end else begin
            case (m_ph)
                0: if (bus_if.start) begin
                    m_ph = 1; e0 = k; m_pol = bus_if.pol; m_timeout = 1'b0; m_busy = 1'b1;
                end
                1: begin
                    el  = k - e0 - 1;
                    a   = samp(k - S);
                    b   = samp(k - S - 1);
                    hit = m_pol ? (!a && b) : (a && !b);
                    if (hit || el == MAXV) begin
                        m_value = el; m_timeout = !hit; m_valid = 1'b1; m_ph = 2;
                    end
                end
                default: if (bus_if.out_ready) begin
                    m_ph = 0; m_valid = 1'b0; m_busy = 1'b0;
                end
            endcase
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic finish_result(string name, int exp_val, bit exp_to, int hold);
        int t = 0;
        while (bus_if.valid !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk({name, " valid"}, bus_if.valid, 1);
        chk({name, " value"}, bus_if.value, exp_val);
        chk({name, " timeout"}, bus_if.timeout, exp_to);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus_if.start = (i == 2);
            chk({name, " held value"}, bus_if.value, exp_val);
            chk({name, " held valid"}, bus_if.valid, 1);
        end
        // Start on the handshake cycle must be ignored as well.
        bus_if.out_ready = 1'b1;
        bus_if.start     = (hold > 0);
        @(negedge clk);
        bus_if.start = 1'b0;
        chk({name, " valid drop"}, bus_if.valid, 0);
        chk({name, " busy drop"}, bus_if.busy, 0);
        @(negedge clk);
        chk({name, " idle"}, bus_if.busy, 0);
    endtask

    task automatic measure(string name, bit p, bit init, int n, int exp_val, bit exp_to, int hold);
        bus_if.pol       = p;
        bus_if.td_in     = init;
        bus_if.out_ready = (hold == 0);
        repeat (4) @(negedge clk);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.pol   = ~p;
        chk({name, " busy"}, bus_if.busy, 1);
        if (n > 0) begin
            repeat (n - 1) @(negedge clk);
            bus_if.td_in = ~init;
        end
        finish_result(name, exp_val, exp_to, hold);
    endtask

    task automatic pre_edge(string name, int lead, int exp_val, bit exp_to);
        bus_if.pol       = 1'b0;
        bus_if.td_in     = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        bus_if.td_in = 1'b1;
        repeat (lead) @(negedge clk);
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        finish_result(name, exp_val, exp_to, 0);
    endtask

    initial begin
        bus_if.start     = 1'b0;
        bus_if.pol       = 1'b0;
        bus_if.td_in     = 1'b0;
        bus_if.out_ready = 1'b1;
        fork
            begin : compare
                forever begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if ({bus_if.valid, bus_if.busy, bus_if.timeout, bus_if.value} !==
                        {m_valid, m_busy, m_timeout, m_value[CNT_W-1:0]}) begin
                        errors++;
                        $display("FAIL model t=%0t: dut v=%0b b=%0b to=%0b val=%0d model v=%0b b=%0b to=%0b val=%0d",
                                 $time, bus_if.valid, bus_if.busy, bus_if.timeout, bus_if.value,
                                 m_valid, m_busy, m_timeout, m_value);
                    end
                end
            end
            begin : stimulus
                repeat (3) @(negedge clk);
                chk("reset valid", bus_if.valid, 0);
                chk("reset busy", bus_if.busy, 0);
                chk("reset value", bus_if.value, 0);
                rst_n = 1'b1;

                measure("rise n5", 1'b0, 1'b0, 5, 6, 1'b0, 0);
                measure("fall n10", 1'b1, 1'b1, 10, 11, 1'b0, 0);
                measure("rise n1", 1'b0, 1'b0, 1, 2, 1'b0, 0);
                pre_edge("edge at accept", 2, MAXV, 1'b1);
                pre_edge("edge before count", 1, 0, 1'b0);
                measure("timeout", 1'b0, 1'b0, 0, MAXV, 1'b1, 0);
                measure("edge at saturation", 1'b0, 1'b0, 254, MAXV, 1'b0, 0);
                measure("edge before saturation", 1'b0, 1'b0, 253, 254, 1'b0, 0);
                measure("backpressure", 1'b0, 1'b0, 3, 4, 1'b0, 7);

                bus_if.pol   = 1'b0;
                bus_if.td_in = 1'b0;
                repeat (4) @(negedge clk);
                bus_if.start = 1'b1;
                @(negedge clk);
                bus_if.start = 1'b0;
                repeat (40) @(negedge clk);
                chk("pre-reset busy", bus_if.busy, 1);
                rst_n = 1'b0;
                #1;
                chk("abort busy", bus_if.busy, 0);
                chk("abort valid", bus_if.valid, 0);
                chk("abort value", bus_if.value, 0);
                chk("abort timeout", bus_if.timeout, 0);
                @(negedge clk);
                rst_n = 1'b1;
                measure("after reset", 1'b1, 1'b1, 7, 8, 1'b0, 0);

                repeat (3) @(negedge clk);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        join_any
    end
endmodule
